// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared opcode/state encodings, ALU op codes and SKIPCOND condition codes
package seq_pkg;

    typedef enum logic [3:0] {
        OP_NOP      = 4'h0,
        OP_LOAD     = 4'h1,
        OP_STORE    = 4'h2,
        OP_ADD      = 4'h3,
        OP_SUB      = 4'h4,
        OP_AND      = 4'h5,
        OP_OR       = 4'h6,
        OP_HALT     = 4'h7,
        OP_SKIPCOND = 4'h8,
        OP_JUMP     = 4'h9
    } opcode_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_FETCH_WAIT,
        ST_LOAD_IR,
        ST_DECODE,
        ST_OPER_WAIT,
        ST_EXEC,
        ST_STORE_WR,
        ST_HALTED
    } state_e;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b1000;
    localparam logic [3:0] ALU_OR  = 4'b1001;

    localparam logic [1:0] SKIP_NEG   = 2'b00;
    localparam logic [1:0] SKIP_ZERO  = 2'b01;
    localparam logic [1:0] SKIP_POS   = 2'b10;
    localparam logic [1:0] SKIP_NEVER = 2'b11;

endpackage

// File: rtl/seq_decode.sv
// rtl/seq_decode.sv - combinational opcode classification and SKIPCOND evaluation
module seq_decode
    import seq_pkg::*;
(
    input  logic [3:0]  opcode,
    input  logic [1:0]  cond,
    input  logic [15:0] ac,
    output logic        needs_operand,
    output logic        is_load,
    output logic        is_store,
    output logic        is_jump,
    output logic        is_skip,
    output logic        is_halt,
    output logic        is_illegal,
    output logic        skip_taken,
    output logic [3:0]  alu_op
);

    always_comb begin
        needs_operand = 1'b0;
        is_load       = 1'b0;
        is_store      = 1'b0;
        is_jump       = 1'b0;
        is_skip       = 1'b0;
        is_halt       = 1'b0;
        is_illegal    = 1'b0;
        alu_op        = ALU_ADD;
        case (opcode)
            OP_NOP:      ;
            OP_LOAD:     begin needs_operand = 1'b1; is_load = 1'b1; end
            OP_STORE:    is_store = 1'b1;
            OP_ADD:      begin needs_operand = 1'b1; alu_op = ALU_ADD; end
            OP_SUB:      begin needs_operand = 1'b1; alu_op = ALU_SUB; end
            OP_AND:      begin needs_operand = 1'b1; alu_op = ALU_AND; end
            OP_OR:       begin needs_operand = 1'b1; alu_op = ALU_OR;  end
            OP_HALT:     is_halt = 1'b1;
            OP_SKIPCOND: is_skip = 1'b1;
            OP_JUMP:     is_jump = 1'b1;
            default:     is_illegal = 1'b1;
        endcase
    end

    // AC is treated as two's complement for the sign tests
    always_comb begin
        skip_taken = 1'b0;
        if (is_skip) begin
            case (cond)
                SKIP_NEG:  skip_taken = ac[15];
                SKIP_ZERO: skip_taken = (ac == 16'h0000);
                SKIP_POS:  skip_taken = !ac[15] && (ac != 16'h0000);
                default:   skip_taken = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - fetch/decode/execute sequencer for a 16-bit accumulator machine
// ILLEGAL_TRAP_EN: when defined, opcodes A-F halt with illegal=1 instead of retiring as NOP.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter logic [11:0] RESET_PC = 12'h000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic [15:0] mem_rdata,
    input  logic [15:0] alu_result,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    output logic [3:0]  alu_op,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [11:0] pc_out,
    output logic [15:0] ac_out,
    output logic [15:0] ir_out,
    output logic        halted,
    output logic        illegal,
    output logic        instr_done
);

    state_e      state;
    logic [11:0] pc;
    logic [11:0] mar;
    logic [15:0] mbr;
    logic [15:0] ir;
    logic [15:0] ac;
    logic        halted_q;
    logic        illegal_q;

    logic needs_operand, is_load, is_store, is_jump, is_skip, is_halt, is_illegal;
    logic skip_taken, trap;

    seq_decode u_decode (
        .opcode        (ir[15:12]),
        .cond          (ir[11:10]),
        .ac            (ac),
        .needs_operand (needs_operand),
        .is_load       (is_load),
        .is_store      (is_store),
        .is_jump       (is_jump),
        .is_skip       (is_skip),
        .is_halt       (is_halt),
        .is_illegal    (is_illegal),
        .skip_taken    (skip_taken),
        .alu_op        (alu_op)
    );

`ifdef ILLEGAL_TRAP_EN
    assign trap = is_illegal;
`else
    assign trap = 1'b0;
`endif

    assign mem_addr   = {4'b0000, mar};
    assign mem_wdata  = mbr;
    assign mem_we     = (state == ST_STORE_WR);
    assign alu_a      = ac;
    assign alu_b      = mem_rdata;
    assign pc_out     = pc;
    assign ac_out     = ac;
    assign ir_out     = ir;
    assign halted     = halted_q;
    assign illegal    = illegal_q;

    // Short instructions (including HALT) retire in DECODE; a trap never retires
    assign instr_done = (state == ST_EXEC) || (state == ST_STORE_WR) ||
                        ((state == ST_DECODE) && !needs_operand && !is_store && !trap);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            pc        <= RESET_PC;
            mar       <= 12'h000;
            mbr       <= 16'h0000;
            ir        <= 16'h0000;
            ac        <= 16'h0000;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (run) state <= ST_FETCH;
                end
                ST_FETCH: begin
                    mar   <= pc;
                    state <= ST_FETCH_WAIT;
                end
                ST_FETCH_WAIT: state <= ST_LOAD_IR;
                ST_LOAD_IR: begin
                    ir    <= mem_rdata;
                    pc    <= pc + 12'd1;
                    state <= ST_DECODE;
                end
                ST_DECODE: begin
                    if (trap) begin
                        halted_q  <= 1'b1;
                        illegal_q <= 1'b1;
                        state     <= ST_HALTED;
                    end else if (is_halt) begin
                        halted_q <= 1'b1;
                        state    <= ST_HALTED;
                    end else if (needs_operand) begin
                        mar   <= ir[11:0];
                        state <= ST_OPER_WAIT;
                    end else if (is_store) begin
                        mar   <= ir[11:0];
                        mbr   <= ac;
                        state <= ST_STORE_WR;
                    end else begin
                        if (is_jump)
                            pc <= ir[11:0];
                        else if (skip_taken)
                            pc <= pc + 12'd1;
                        state <= run ? ST_FETCH : ST_IDLE;
                    end
                end
                ST_OPER_WAIT: state <= ST_EXEC;
                ST_EXEC: begin
                    ac    <= is_load ? mem_rdata : alu_result;
                    state <= run ? ST_FETCH : ST_IDLE;
                end
                ST_STORE_WR: state <= run ? ST_FETCH : ST_IDLE;
                ST_HALTED:   state <= ST_HALTED;
                default:     state <= ST_IDLE;
            endcase
        end
    end

endmodule
